// File: rtl/ps2_button_mapper_pkg.sv
// Shared types and constants for the PS/2 button mapper and its helpers.
package ps2_button_mapper_pkg;

  localparam int BTN_IDX_W = 8;

  localparam int BTN_RIGHT = 0;
  localparam int BTN_LEFT  = 1;
  localparam int BTN_DOWN  = 2;
  localparam int BTN_UP    = 3;

  localparam int TOGGLE  = 10;
  localparam int PRESSED = 9;
  localparam int EXT     = 8;

  typedef struct packed {
    logic                 valid;
    logic [8:0]           code;
    logic [BTN_IDX_W-1:0] btn;
  } map_entry_t;

  // Quarter turn for a horizontally mounted monitor.
  function automatic logic [3:0] rotate_dirs(input logic [3:0] raw);
    logic [3:0] r;
    r            = '0;
    r[BTN_UP]    = raw[BTN_LEFT];
    r[BTN_DOWN]  = raw[BTN_RIGHT];
    r[BTN_LEFT]  = raw[BTN_DOWN];
    r[BTN_RIGHT] = raw[BTN_UP];
    return r;
  endfunction

endpackage

// File: rtl/ps2_button_mapper_coin_stretcher.sv
// Rising-edge detector on a masked level vector that fires a retriggerable
// fixed-length pulse; shared with service and tilt inputs of other cores.
module coin_stretcher
  import ps2_button_mapper_pkg::*;
#(
  parameter int          W         = 16,
  parameter logic [15:0] PULSE_CYC = 16'd1000,
  parameter logic [W-1:0] MASK     = '1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] level_i,
  output logic         pulse_o
);

  logic [W-1:0] prev_q;
  logic [15:0]  cnt_q, cnt_d;
  logic         pulse_q, pulse_d;
  logic         rise;

  assign rise = |(level_i & ~prev_q & MASK);

  // A new edge always reloads, so overlapping triggers extend the pulse.
  always_comb begin
    cnt_d   = cnt_q;
    pulse_d = pulse_q;
    if (rise) begin
      cnt_d   = PULSE_CYC;
      pulse_d = 1'b1;
    end else if (cnt_q != 16'd0) begin
      cnt_d   = cnt_q - 16'd1;
      pulse_d = (cnt_q != 16'd1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q  <= '0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      prev_q  <= level_i;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/ps2_button_mapper.sv
// Runtime-programmable PS/2 key map to arcade buttons with joystick OR,
// direction rotation and coin pulse. Optional autofire: PS2_BUTTON_MAPPER_AUTOFIRE_EN.
module ps2_button_mapper
  import ps2_button_mapper_pkg::*;
#(
  parameter int               N_BTN          = 16,
  parameter int               N_MAP          = 32,
  parameter logic [15:0]      COIN_PULSE_CYC = 16'd1000,
  parameter logic [N_BTN-1:0] COIN_MASK      = 16'h0060
`ifdef PS2_BUTTON_MAPPER_AUTOFIRE_EN
  ,
  parameter logic [19:0]      AUTOFIRE_DIV   = 20'd400000
`endif
) (
  input  logic                       clk_sys,
  input  logic                       reset_n,
  input  logic [10:0]                ps2_key,
  input  logic [N_BTN-1:0]           joy_in,
  input  logic                       rot,
  input  logic                       map_we,
  input  logic [$clog2(N_MAP)-1:0]   map_addr,
  input  logic [8:0]                 map_code,
  input  logic [$clog2(N_BTN)-1:0]   map_btn,
  input  logic                       map_valid,
`ifdef PS2_BUTTON_MAPPER_AUTOFIRE_EN
  input  logic [N_BTN-1:0]           autofire_mask,
`endif
  output logic [N_BTN-1:0]           btn_out,
  output logic                       coin_out
);

  localparam int AW = $clog2(N_MAP);

  logic             tog_q;
  logic             ev_q;
  logic [9:0]       key_q;
  map_entry_t       map_q [N_MAP];
  map_entry_t       wr_entry;
  logic [N_MAP-1:0] held_q, held_d;
  logic [N_BTN-1:0] kbd, raw, btn_d, btn_q;

  // Any change of the toggle bit marks a fresh key event from hps_io.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      tog_q <= 1'b0;
      ev_q  <= 1'b0;
      key_q <= '0;
    end else begin
      tog_q <= ps2_key[TOGGLE];
      ev_q  <= ps2_key[TOGGLE] ^ tog_q;
      key_q <= ps2_key[PRESSED:0];
    end
  end

  always_comb begin
    wr_entry       = '0;
    wr_entry.valid = map_valid;
    wr_entry.code  = map_code;
    wr_entry.btn   = BTN_IDX_W'(map_btn);
  end

  // Write clears after the match so a same-cycle rewrite wins.
  always_comb begin
    held_d = held_q;
    for (int i = 0; i < N_MAP; i++) begin
      if (ev_q && map_q[i].valid && (map_q[i].code == key_q[EXT:0]))
        held_d[i] = key_q[PRESSED];
      if (map_we && (map_addr == AW'(i)))
        held_d[i] = 1'b0;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_MAP; i++) map_q[i] <= '0;
      held_q <= '0;
    end else begin
      held_q <= held_d;
      if (map_we) map_q[map_addr] <= wr_entry;
    end
  end

  always_comb begin
    kbd = '0;
    for (int b = 0; b < N_BTN; b++) begin
      for (int i = 0; i < N_MAP; i++) begin
        if (map_q[i].valid && held_q[i] && (map_q[i].btn == BTN_IDX_W'(b)))
          kbd[b] = 1'b1;
      end
    end
  end

  assign raw = kbd | joy_in;

`ifdef PS2_BUTTON_MAPPER_AUTOFIRE_EN
  logic [19:0] div_q;
  logic        phase_q;

  // Phase starts high so the first press reaches the core immediately.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      div_q   <= '0;
      phase_q <= 1'b1;
    end else if (div_q == AUTOFIRE_DIV - 20'd1) begin
      div_q   <= '0;
      phase_q <= ~phase_q;
    end else begin
      div_q <= div_q + 20'd1;
    end
  end
`endif

  always_comb begin
    btn_d = raw;
    if (rot) btn_d[3:0] = rotate_dirs(raw[3:0]);
`ifdef PS2_BUTTON_MAPPER_AUTOFIRE_EN
    btn_d = btn_d & ~(autofire_mask & {N_BTN{~phase_q}});
`endif
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) btn_q <= '0;
    else          btn_q <= btn_d;
  end

  assign btn_out = btn_q;

  coin_stretcher #(
    .W         (N_BTN),
    .PULSE_CYC (COIN_PULSE_CYC),
    .MASK      (COIN_MASK)
  ) u_coin (
    .clk_i   (clk_sys),
    .rst_ni  (reset_n),
    .level_i (btn_q),
    .pulse_o (coin_out)
  );

endmodule

// File: tb/tb_ps2_button_mapper.sv
// Self-checking bench for ps2_button_mapper: directed sequences, a rotation
// vector table and a randomized run against a behavioural reference model.
module tb_ps2_button_mapper;

  localparam int          CPC   = 4;
  localparam logic [15:0] CMASK = 16'h0060;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic [10:0] ps2_key = '0;
  logic [15:0] joy_in = '0;
  logic        rot = 1'b0;
  logic        map_we = 1'b0;
  logic [4:0]  map_addr = '0;
  logic [8:0]  map_code = '0;
  logic [3:0]  map_btn = '0;
  logic        map_valid = 1'b0;
  logic [15:0] btn_out;
  logic        coin_out;

  int checks = 0;
  int errors = 0;

  always #5 clk_sys = ~clk_sys;

  ps2_button_mapper #(
    .N_BTN          (16),
    .N_MAP          (32),
    .COIN_PULSE_CYC (16'(CPC)),
    .COIN_MASK      (CMASK)
  ) dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .ps2_key   (ps2_key),
    .joy_in    (joy_in),
    .rot       (rot),
    .map_we    (map_we),
    .map_addr  (map_addr),
    .map_code  (map_code),
    .map_btn   (map_btn),
    .map_valid (map_valid),
    .btn_out   (btn_out),
    .coin_out  (coin_out)
  );

  typedef struct {
    logic [15:0] joy;
    logic        rot;
    logic [15:0] exp;
  } vec_t;

  vec_t       tbl [10];
  logic [8:0] codes [5];

  // Reference model state
  logic       mValid [32];
  logic [8:0] mCode  [32];
  int         mBtn   [32];
  logic       mHeld  [32];
  logic       mTog, peValid, pePressed;
  logic [8:0] peCode;
  logic [15:0] b1, b2, kbd, rawv, expBtn;
  logic       expCoin;
  int         lastLoad;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic applyStimulus(input logic [15:0] joy, input logic r);
    joy_in = joy;
    rot    = r;
  endtask

  task automatic doReset();
    reset_n = 1'b0;
    ps2_key = '0;
    joy_in  = '0;
    rot     = 1'b0;
    map_we  = 1'b0;
    step(2);
    reset_n = 1'b1;
    step(1);
  endtask

  task automatic writeMap(input logic [4:0] a, input logic [8:0] c, input logic [3:0] b, input logic v);
    map_we    = 1'b1;
    map_addr  = a;
    map_code  = c;
    map_btn   = b;
    map_valid = v;
    step(1);
    map_we = 1'b0;
  endtask

  task automatic keyEvent(input logic pressed, input logic [8:0] code);
    ps2_key = {~ps2_key[10], pressed, code};
  endtask

  task automatic runCoin(input string name, input logic [11:0] joyBits, input logic [11:0] expPat);
    logic [11:0] pat;
    pat = '0;
    for (int k = 0; k < 12; k++) begin
      joy_in = joyBits[k] ? 16'h0020 : 16'h0000;
      step(1);
      pat[k] = coin_out;
    end
    checkOutput(name, 32'(pat), 32'(expPat));
  endtask

  initial begin
    codes[0] = 9'h029; codes[1] = 9'h014; codes[2] = 9'h11C;
    codes[3] = 9'h01C; codes[4] = 9'h175;

    tbl[0] = '{16'h0002, 1'b1, 16'h0008};
    tbl[1] = '{16'h0002, 1'b0, 16'h0002};
    tbl[2] = '{16'h0001, 1'b1, 16'h0004};
    tbl[3] = '{16'h0004, 1'b1, 16'h0002};
    tbl[4] = '{16'h0008, 1'b1, 16'h0001};
    tbl[5] = '{16'h000F, 1'b1, 16'h000F};
    tbl[6] = '{16'h0005, 1'b1, 16'h0006};
    tbl[7] = '{16'h8010, 1'b1, 16'h8010};
    tbl[8] = '{16'h000A, 1'b1, 16'h0009};
    tbl[9] = '{16'h000A, 1'b0, 16'h000A};

    doReset();
    checkOutput("reset_btn", 32'(btn_out), 32'h0);
    checkOutput("reset_coin", 32'(coin_out), 32'h0);

    // Single key: exactly three cycles to btn_out in both directions.
    writeMap(5'd0, 9'h029, 4'd4, 1'b1);
    keyEvent(1'b1, 9'h029);
    step(2);
    checkOutput("press_early", 32'(btn_out), 32'h0);
    step(1);
    checkOutput("press_lat3", 32'(btn_out), 32'h0010);
    keyEvent(1'b0, 9'h029);
    step(2);
    checkOutput("release_early", 32'(btn_out), 32'h0010);
    step(1);
    checkOutput("release_lat3", 32'(btn_out), 32'h0);

    // Two keys sharing one button.
    doReset();
    writeMap(5'd1, 9'h029, 4'd4, 1'b1);
    writeMap(5'd2, 9'h014, 4'd4, 1'b1);
    keyEvent(1'b1, 9'h029); step(3);
    checkOutput("share_space", 32'(btn_out), 32'h0010);
    keyEvent(1'b1, 9'h014); step(3);
    checkOutput("share_both", 32'(btn_out), 32'h0010);
    keyEvent(1'b0, 9'h029); step(3);
    checkOutput("share_ctrl_only", 32'(btn_out), 32'h0010);
    keyEvent(1'b0, 9'h014); step(3);
    checkOutput("share_none", 32'(btn_out), 32'h0);

    // Rotation table, one-cycle joystick latency.
    doReset();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(tbl[i].joy, tbl[i].rot);
      step(1);
      checkOutput($sformatf("rot_vec%0d", i), 32'(btn_out), 32'(tbl[i].exp));
    end

    // Coin pulse length and retrigger.
    doReset();
    runCoin("coin_single", 12'hFFF, 12'h01E);
    doReset();
    runCoin("coin_retrig", 12'h005, 12'h07E);

    // Rewriting a held entry drops its button two cycles after map_we.
    doReset();
    writeMap(5'd3, 9'h01C, 4'd7, 1'b1);
    keyEvent(1'b1, 9'h01C); step(3);
    checkOutput("hold_e3", 32'(btn_out), 32'h0080);
    ps2_key = {ps2_key[10], 1'b0, 9'h01C};
    step(4);
    checkOutput("no_toggle_no_event", 32'(btn_out), 32'h0080);
    writeMap(5'd3, 9'h01C, 4'd7, 1'b1);
    checkOutput("rewrite_early", 32'(btn_out), 32'h0080);
    step(1);
    checkOutput("rewrite_drop", 32'(btn_out), 32'h0);

    // Asynchronous reset in the middle of a coin pulse.
    doReset();
    writeMap(5'd0, 9'h029, 4'd4, 1'b1);
    keyEvent(1'b1, 9'h029);
    joy_in = 16'h0020;
    step(3);
    checkOutput("pre_reset_btn", 32'(btn_out), 32'h0030);
    checkOutput("pre_reset_coin", 32'(coin_out), 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async_reset_btn", 32'(btn_out), 32'h0);
    checkOutput("async_reset_coin", 32'(coin_out), 32'h0);
    joy_in = '0;
    #2;
    reset_n = 1'b1;
    step(1);
    keyEvent(1'b1, 9'h029); step(4);
    checkOutput("post_reset_map_invalid", 32'(btn_out), 32'h0);
    keyEvent(1'b1, 9'h029); step(4);
    checkOutput("post_reset_map_invalid2", 32'(btn_out), 32'h0);

    // Randomized run against the reference model.
    doReset();
    for (int i = 0; i < 32; i++) begin
      mValid[i] = 1'b0; mCode[i] = '0; mBtn[i] = 0; mHeld[i] = 1'b0;
    end
    mTog = 1'b0; peValid = 1'b0; pePressed = 1'b0; peCode = '0;
    b1 = '0; b2 = '0; lastLoad = -100;
    for (int t = 0; t < 400; t++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 30)      ps2_key = {~ps2_key[10], 1'($urandom_range(0, 1)), codes[$urandom_range(0, 4)]};
      else if (r < 40) ps2_key = {ps2_key[10], 1'($urandom_range(0, 1)), codes[$urandom_range(0, 4)]};
      map_we    = ($urandom_range(0, 9) == 0);
      map_addr  = 5'($urandom_range(0, 7));
      map_code  = codes[$urandom_range(0, 4)];
      map_btn   = 4'($urandom_range(0, 15));
      map_valid = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 4) == 0) joy_in = 16'($urandom) & 16'h807F;
      if ($urandom_range(0, 19) == 0) rot = ~rot;

      // Button vector seen at this edge, from state before the edge.
      kbd = '0;
      for (int i = 0; i < 32; i++)
        if (mValid[i] && mHeld[i] && mBtn[i] < 16) kbd[mBtn[i]] = 1'b1;
      rawv   = kbd | joy_in;
      expBtn = rawv;
      if (rot) begin
        expBtn[3] = rawv[1];
        expBtn[2] = rawv[0];
        expBtn[1] = rawv[2];
        expBtn[0] = rawv[3];
      end
      if ((b1 & ~b2 & CMASK) != 16'h0) lastLoad = t;
      expCoin = ((t - lastLoad) < CPC);
      b2 = b1;
      b1 = expBtn;

      if (peValid)
        for (int i = 0; i < 32; i++)
          if (mValid[i] && mCode[i] == peCode) mHeld[i] = pePressed;
      if (map_we) begin
        mValid[map_addr] = map_valid;
        mCode[map_addr]  = map_code;
        mBtn[map_addr]   = int'(map_btn);
        mHeld[map_addr]  = 1'b0;
      end
      peValid   = (ps2_key[10] != mTog);
      pePressed = ps2_key[9];
      peCode    = ps2_key[8:0];
      mTog      = ps2_key[10];

      step(1);
      checkOutput("rand_btn", 32'(btn_out), 32'(expBtn));
      checkOutput("rand_coin", 32'(coin_out), 32'(expCoin));
    end
    map_we = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
